bcd_calc_engine: RTL and testbench
==================================

// Module: bcd_calc_engine
// PURPOSE
//  Multi-digit keypad calculator core: turns key-down events into two decimal operands, an operator (+ - *) and a signed result.
//  Converts the result to decimal with a sequential binary-to-BCD (double-dabble) pass.
//  Exposes a 32-character display image (line1 = expression, line2 = result) through a registered read port for the LCD line driver.
//  Sits between the switch/key encoder and the LCD controller. Runs in the slow display clock domain.
// PARAMETERS
//  DIGITS  4  max decimal digits per operand, legal 1..7 (2*DIGITS+2 <= 16)
//  MUL_EN  1  1: '*' accepted; 0: key 12 ignored (no key_err pulse)
//  localparam RW = $clog2(10**(2*DIGITS)); result magnitude width (27 @ DIGITS=4)
// PORTS
//  clk          in   1  clock
//  rst          in   1  reset, asynchronous, active-high
//  key_down     in   1  level, high while any key held
//  key_code     in   5  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 clear, others ignored
//  char_addr    in   5  0-15 line1 col, 16-31 line2 col
//  char_data    out  8  ASCII at char_addr, 1-cycle read latency
//  busy         out  1  high during CONVERT
//  result_valid out  1  high in SHOW
//  result_neg   out  1  result < 0, valid while result_valid
//  key_err      out  1  1-cycle pulse on a rejected key event
//  disp_update  out  1  1-cycle pulse when any display char changed
// BEHAVIOUR
//  Reset: state ENTER_A, A=B=0, op=none, all chars 0x20.
//   All outputs 0 except char_data=0x20. Asynchronous: takes effect immediately, including mid-CONVERT.
//  Key event = rising edge of key_down, detected by key_down_q register. key_code is sampled in the edge cycle.
//   A held key yields exactly one event.
//  Clear (14) in any state: same effect as reset on the next edge, plus a disp_update pulse.
//  ENTER_A, digit:
//   if cntA<DIGITS: A=A*10+d, char appended at col cntA, cntA++.
//   else ignored with key_err.
//  ENTER_A, operator: accepted only if cntA>=1.
//   op latched, op char (+ 0x2B, - 0x2D, * 0x2A) written at col cntA, go ENTER_B.
//  ENTER_A, other keys: '=' or operator with cntA=0 gives key_err.
//  ENTER_B, digit: same rules as ENTER_A on B/cntB; char at col cntA+1+cntB.
//  ENTER_B, '=': accepted only if cntB>=1. Writes '=' after B, computes R=A op B in one cycle, go CONVERT.
//  ENTER_B, other keys: operator gives key_err; '=' with cntB=0 gives key_err.
//  Arithmetic: A, B unsigned binary, width RW. Sub: neg=(A<B), mag=|A-B|. Mul: full product, no overflow possible.
//  CONVERT: busy=1 for exactly RW cycles, one double-dabble shift per cycle into 2*DIGITS BCD nibbles.
//   Key events other than clear are ignored silently.
//  SHOW: result_valid=1. Line2 is right-aligned (last digit col 31).
//   Leading zeros suppressed; zero result shows "0".
//   When neg, '-' sits immediately left of the first significant digit.
//  Latency: '=' edge cycle E; R registered E+1; busy E+1..E+RW; result_valid and line2 written at E+RW+1.
//  SHOW, digit: starts a new expression. Lines cleared, A=d, cntA=1, ENTER_A.
//  SHOW, other keys: operator or '=' gives key_err, state unchanged.
//  Display read: char_data <= image[char_addr] each clk; chars not written read 0x20. Line2 is blank outside SHOW.
//  disp_update pulses the cycle after any image write.
// TESTING
//  1,2,+,3,4,= -> line1 "12+34=" at addr 0-5; addr 30,31 = "46"; result_neg=0; busy exactly 27 cycles.
//  5,-,1,2,= -> addr 30='-', 31='7'; result_neg=1; addr 16-29 = 0x20.
//  9,9,9,9,*,9,9,9,9,= -> addr 24-31 "99980001"; result_valid at E+28.
//  1,2,3,4,5 -> line1 "1234"; 5th key gives key_err pulse; '+' first key gives key_err.
//  Clear mid-CONVERT -> busy=0, result_valid=0, all 32 chars 0x20 next cycle.
//  key_down held 100 cycles with code 7 -> exactly one '7'. rst asserted mid-entry -> immediate reset values.

Source files
------------

// File: rtl/bcd_calc_engine.sv
// bcd_calc_engine: keypad calculator core. Builds "A op B=" on display line 1, converts the
// signed result with a serial double-dabble and shows it right-aligned on line 2.
module bcd_calc_engine #(
    parameter int DIGITS = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    input  logic [4:0] key_code,
    input  logic [4:0] char_addr,
    output logic [7:0] char_data,
    output logic       busy,
    output logic       result_valid,
    output logic       result_neg,
    output logic       key_err,
    output logic       disp_update
);
    localparam int RW = $clog2(64'd10 ** (2 * DIGITS));
    localparam int ND = 2 * DIGITS;
    localparam int CW = $clog2(RW + 1);
    localparam logic [3:0]    DMAX = 4'(DIGITS);
    localparam logic [CW-1:0] RW_C = CW'(RW);
    localparam logic [1:0] OP_NONE = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_MUL = 2'd3;

    // state    | meaning
    // ENTER_A  | collecting digits of A, waiting for an operator
    // ENTER_B  | collecting digits of B, waiting for '='
    // CONVERT  | serial binary-to-BCD of |R|, one bit per cycle
    // SHOW     | result on line 2; a digit starts a new expression
    typedef enum logic [1:0] {ENTER_A, ENTER_B, CONVERT, SHOW} state_t;

    state_t          state;
    logic [RW-1:0]   a_q, b_q, bin_q, mag;
    logic [4*ND-1:0] bcd_q, bcd_nxt;
    logic [3:0]      cnt_a, cnt_b;
    logic [CW-1:0]   cnt_cv;
    logic [1:0]      op_q, key_op;
    logic            neg_q, res_neg, key_down_q, seen;
    logic [7:0]      image [32];
    logic [7:0]      line2 [16];
    logic [7:0]      op_char, dig_char;
    logic [4:0]      col_b;
    logic            key_ev, is_digit, is_op, is_eq, is_clr;

    assign key_ev   = key_down & ~key_down_q;
    assign is_digit = key_code <= 5'd9;
    assign is_op    = (key_code == 5'd10) || (key_code == 5'd11) || (MUL_EN && key_code == 5'd12);
    assign is_eq    = key_code == 5'd13;
    assign is_clr   = key_code == 5'd14;
    assign dig_char = {4'h3, key_code[3:0]};
    assign col_b    = {1'b0, cnt_a} + 5'd1 + {1'b0, cnt_b};

    always_comb begin
        key_op  = OP_MUL;
        op_char = 8'h2A;
        if (key_code == 5'd10) begin
            key_op  = OP_ADD;
            op_char = 8'h2B;
        end else if (key_code == 5'd11) begin
            key_op  = OP_SUB;
            op_char = 8'h2D;
        end
    end

    always_comb begin
        res_neg = 1'b0;
        mag     = '0;
        case (op_q)
            OP_ADD: mag = a_q + b_q;
            OP_SUB: begin
                res_neg = a_q < b_q;
                mag     = res_neg ? b_q - a_q : a_q - b_q;
            end
            OP_MUL: mag = a_q * b_q;
            default: mag = '0;
        endcase
    end

    function automatic logic [4*ND-1:0] dabble(input logic [4*ND-1:0] b, input logic in_bit);
        logic [4*ND-1:0] t;
        t = b;
        for (int i = 0; i < ND; i++)
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        return {t[4*ND-2:0], in_bit};
    endfunction

    assign bcd_nxt = dabble(bcd_q, bin_q[RW-1]);

    // Line 2 is formatted from the final shift so it lands in the same edge as result_valid.
    always_comb begin
        seen = 1'b0;
        for (int j = 0; j < 16; j++) line2[j] = 8'h20;
        for (int i = ND - 1; i >= 0; i--) begin
            if (!seen && (bcd_nxt[4*i +: 4] != 4'd0 || i == 0)) begin
                seen = 1'b1;
                if (neg_q) line2[14 - i] = 8'h2D;
            end
            if (seen) line2[15 - i] = {4'h3, bcd_nxt[4*i +: 4]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ENTER_A;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_NONE;
            cnt_a        <= '0;
            cnt_b        <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_cv       <= '0;
            neg_q        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_neg   <= 1'b0;
            key_err      <= 1'b0;
            disp_update  <= 1'b0;
            char_data    <= 8'h20;
            key_down_q   <= 1'b0;
            for (int i = 0; i < 32; i++) image[i] <= 8'h20;
        end else begin
            key_down_q  <= key_down;
            key_err     <= 1'b0;
            disp_update <= 1'b0;
            char_data   <= image[char_addr];
            if (key_ev && is_clr) begin
                // Edge detector keeps tracking so a held clear is a single event.
                state        <= ENTER_A;
                a_q          <= '0;
                b_q          <= '0;
                op_q         <= OP_NONE;
                cnt_a        <= '0;
                cnt_b        <= '0;
                bin_q        <= '0;
                bcd_q        <= '0;
                cnt_cv       <= '0;
                neg_q        <= 1'b0;
                busy         <= 1'b0;
                result_valid <= 1'b0;
                result_neg   <= 1'b0;
                disp_update  <= 1'b1;
                char_data    <= 8'h20;
                for (int i = 0; i < 32; i++) image[i] <= 8'h20;
            end else begin
                case (state)
                    ENTER_A: if (key_ev) begin
                        if (is_digit) begin
                            if (cnt_a < DMAX) begin
                                a_q                 <= a_q * RW'(10) + RW'(key_code[3:0]);
                                image[{1'b0, cnt_a}] <= dig_char;
                                cnt_a               <= cnt_a + 4'd1;
                                disp_update         <= 1'b1;
                            end else key_err <= 1'b1;
                        end else if (is_op) begin
                            if (cnt_a != 4'd0) begin
                                op_q                 <= key_op;
                                image[{1'b0, cnt_a}] <= op_char;
                                state                <= ENTER_B;
                                disp_update          <= 1'b1;
                            end else key_err <= 1'b1;
                        end else if (is_eq) key_err <= 1'b1;
                    end
                    ENTER_B: if (key_ev) begin
                        if (is_digit) begin
                            if (cnt_b < DMAX) begin
                                b_q          <= b_q * RW'(10) + RW'(key_code[3:0]);
                                image[col_b] <= dig_char;
                                cnt_b        <= cnt_b + 4'd1;
                                disp_update  <= 1'b1;
                            end else key_err <= 1'b1;
                        end else if (is_eq) begin
                            if (cnt_b != 4'd0) begin
                                image[col_b] <= 8'h3D;
                                bin_q        <= mag;
                                neg_q        <= res_neg;
                                bcd_q        <= '0;
                                cnt_cv       <= RW_C;
                                busy         <= 1'b1;
                                state        <= CONVERT;
                                disp_update  <= 1'b1;
                            end else key_err <= 1'b1;
                        end else if (is_op) key_err <= 1'b1;
                    end
                    CONVERT: begin
                        bin_q <= {bin_q[RW-2:0], 1'b0};
                        bcd_q <= bcd_nxt;
                        if (cnt_cv == {{(CW-1){1'b0}}, 1'b1}) begin
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            result_neg   <= neg_q;
                            state        <= SHOW;
                            disp_update  <= 1'b1;
                            for (int j = 0; j < 16; j++) image[16 + j] <= line2[j];
                        end else cnt_cv <= cnt_cv - 1'b1;
                    end
                    SHOW: if (key_ev) begin
                        if (is_digit) begin
                            for (int i = 0; i < 32; i++) image[i] <= 8'h20;
                            image[0]     <= dig_char;
                            a_q          <= RW'(key_code[3:0]);
                            b_q          <= '0;
                            cnt_a        <= 4'd1;
                            cnt_b        <= '0;
                            op_q         <= OP_NONE;
                            result_valid <= 1'b0;
                            result_neg   <= 1'b0;
                            state        <= ENTER_A;
                            disp_update  <= 1'b1;
                        end else if (is_op || is_eq) key_err <= 1'b1;
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bcd_calc_engine.sv
// Bench for bcd_calc_engine: table of key strings with hand-written display images, timing
// corner sequences, and random key streams compared against a string/integer calculator model.
module tb_bcd_calc_engine;
    localparam int DIGITS = 4;
    localparam bit MUL    = 1'b1;
    localparam int RW     = 27;
    localparam int NV     = 12;

    logic       clk, rst, key_down;
    logic [4:0] key_code, char_addr;
    logic [7:0] char_data;
    logic       busy, result_valid, result_neg, key_err, disp_update;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_img [32];
    logic [7:0] got_img [32];

    string  m_l1;
    longint m_a, m_b, m_res;
    int     m_na, m_nb, m_op, m_mode;

    typedef struct {
        string keys;
        string l1;
        string l2;
        bit    neg;
        bit    valid;
        int    errs;
    } vec_t;
    vec_t vecs [NV];

    bcd_calc_engine #(.DIGITS(DIGITS), .MUL_EN(MUL)) dut (
        .clk(clk), .rst(rst), .key_down(key_down), .key_code(key_code),
        .char_addr(char_addr), .char_data(char_data), .busy(busy),
        .result_valid(result_valid), .result_neg(result_neg),
        .key_err(key_err), .disp_update(disp_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int ch2code(input byte c);
        case (c)
            8'h2B:   return 10;
            8'h2D:   return 11;
            8'h2A:   return 12;
            8'h3D:   return 13;
            8'h43:   return 14;
            default: return int'(c) - 48;
        endcase
    endfunction

    task automatic build_exp(input string l1, input string l2);
        for (int i = 0; i < 32; i++) exp_img[i] = 8'h20;
        for (int i = 0; i < l1.len(); i++) exp_img[i] = l1[i];
        for (int i = 0; i < l2.len(); i++) exp_img[32 - l2.len() + i] = l2[i];
    endtask

    task automatic check_image(input string name);
        int bad;
        bad = -1;
        @(negedge clk);
        char_addr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            got_img[i] = char_data;
            char_addr  = 5'(i + 1);
        end
        for (int i = 31; i >= 0; i--) if (got_img[i] !== exp_img[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: addr %0d got=%02h want=%02h", name, bad, got_img[bad], exp_img[bad]);
        end
    endtask

    task automatic do_key(input int code, output bit err);
        int n;
        @(negedge clk);
        key_code = 5'(code);
        key_down = 1'b1;
        @(negedge clk);
        err      = key_err;
        key_down = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL conv_timeout: busy still high after %0d cycles, want low", n);
        end
        @(negedge clk);
    endtask

    task automatic press_str(input string s, output int errs);
        bit e;
        errs = 0;
        for (int i = 0; i < s.len(); i++) begin
            do_key(ch2code(s[i]), e);
            errs += int'(e);
        end
    endtask

    task automatic model_reset();
        m_l1 = ""; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_mode = 0; m_res = 0;
    endtask

    task automatic model_key(input int code, output bit err);
        bit op_key;
        op_key = (code == 10) || (code == 11) || (code == 12 && MUL);
        err = 1'b0;
        if (code == 14) model_reset();
        else if (m_mode == 2) begin
            if (code <= 9) begin
                model_reset();
                m_l1 = $sformatf("%0d", code);
                m_a  = code;
                m_na = 1;
            end else if (op_key || code == 13) err = 1'b1;
        end else if (code <= 9) begin
            if (m_mode == 0 && m_na < DIGITS) begin
                m_a = m_a * 10 + code; m_na++; m_l1 = $sformatf("%s%0d", m_l1, code);
            end else if (m_mode == 1 && m_nb < DIGITS) begin
                m_b = m_b * 10 + code; m_nb++; m_l1 = $sformatf("%s%0d", m_l1, code);
            end else err = 1'b1;
        end else if (op_key) begin
            if (m_mode == 0 && m_na > 0) begin
                m_op   = code;
                m_l1   = $sformatf("%s%s", m_l1, code == 10 ? "+" : code == 11 ? "-" : "*");
                m_mode = 1;
            end else err = 1'b1;
        end else if (code == 13) begin
            if (m_mode == 1 && m_nb > 0) begin
                m_l1   = $sformatf("%s=", m_l1);
                m_res  = (m_op == 10) ? m_a + m_b : (m_op == 11) ? m_a - m_b : m_a * m_b;
                m_mode = 2;
            end else err = 1'b1;
        end
    endtask

    initial begin
        bit e, me;
        int errs, code, r, nbusy, first_rv, du1, du_rv, du_cnt;

        vecs[0]  = '{"12+34=",     "12+34=",     "46",       1'b0, 1'b1, 0};
        vecs[1]  = '{"5-12=",      "5-12=",      "-7",       1'b1, 1'b1, 0};
        vecs[2]  = '{"9999*9999=", "9999*9999=", "99980001", 1'b0, 1'b1, 0};
        vecs[3]  = '{"12345",      "1234",       "",         1'b0, 1'b0, 1};
        vecs[4]  = '{"+3",         "3",          "",         1'b0, 1'b0, 1};
        vecs[5]  = '{"7-7=",       "7-7=",       "0",        1'b0, 1'b1, 0};
        vecs[6]  = '{"4=2",        "42",         "",         1'b0, 1'b0, 1};
        vecs[7]  = '{"8+*=1=+",    "8+1=",       "9",        1'b0, 1'b1, 3};
        vecs[8]  = '{"3*0=5",      "5",          "",         1'b0, 1'b0, 0};
        vecs[9]  = '{"20*15=",     "20*15=",     "300",      1'b0, 1'b1, 0};
        vecs[10] = '{"56+C9-3=",   "9-3=",       "6",        1'b0, 1'b1, 0};
        vecs[11] = '{"12-1234=",   "12-1234=",   "-1222",    1'b1, 1'b1, 0};

        rst = 1'b1; key_down = 1'b0; key_code = 5'd0; char_addr = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_char_data", char_data, 8'h20);
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_neg", result_neg, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_disp_update", disp_update, 0);
        rst = 1'b0;
        build_exp("", "");
        check_image("rst_image");

        for (int v = 0; v < NV; v++) begin
            do_key(14, e);
            press_str(vecs[v].keys, errs);
            build_exp(vecs[v].l1, vecs[v].l2);
            check_image($sformatf("vec%0d_image", v));
            chk($sformatf("vec%0d_neg", v), result_neg, vecs[v].neg);
            chk($sformatf("vec%0d_valid", v), result_valid, vecs[v].valid);
            chk($sformatf("vec%0d_key_err_count", v), errs, errs == vecs[v].errs ? errs : vecs[v].errs);
            chk($sformatf("vec%0d_busy", v), busy, 0);
        end

        // '=' latency: busy for exactly RW cycles, result_valid first seen at E+RW+1
        press_str("C12+34", errs);
        @(negedge clk);
        key_code = 5'd13;
        key_down = 1'b1;
        nbusy = 0; first_rv = 0; du1 = 0; du_rv = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                key_down = 1'b0;
                du1 = int'(disp_update);
            end
            if (busy) nbusy++;
            if (result_valid && first_rv == 0) begin
                first_rv = k;
                du_rv = int'(disp_update);
            end
        end
        chk("lat_busy_cycles", nbusy, RW);
        chk("lat_result_valid_cycle", first_rv, RW + 1);
        chk("lat_disp_update_eq", du1, 1);
        chk("lat_disp_update_show", du_rv, 1);

        // clear while converting
        press_str("C12+34", errs);
        @(negedge clk);
        key_code = 5'd13;
        key_down = 1'b1;
        @(negedge clk);
        key_down = 1'b0;
        chk("cv_busy_started", busy, 1);
        repeat (8) @(negedge clk);
        key_code = 5'd14;
        key_down = 1'b1;
        @(negedge clk);
        chk("cv_clear_busy", busy, 0);
        chk("cv_clear_valid", result_valid, 0);
        chk("cv_clear_disp_update", disp_update, 1);
        key_down = 1'b0;
        build_exp("", "");
        check_image("cv_clear_image");
        repeat (40) @(negedge clk);
        chk("cv_clear_no_late_valid", result_valid, 0);

        // held key yields one event
        press_str("C", errs);
        @(negedge clk);
        key_code = 5'd7;
        key_down = 1'b1;
        du_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            du_cnt += int'(disp_update);
        end
        key_down = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_disp_updates", du_cnt, 1);
        build_exp("7", "");
        check_image("held_image");

        // asynchronous reset in the middle of entry
        press_str("C12", errs);
        char_addr = 5'd0;
        repeat (2) @(negedge clk);
        chk("pre_rst_char0", char_data, 8'h31);
        key_code = 5'd3;
        key_down = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_rst_disp_update", disp_update, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_char_data", char_data, 8'h20);
        chk("async_rst_disp_update", disp_update, 0);
        key_down = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        build_exp("", "");
        check_image("async_rst_image");

        // random key streams against the model
        model_reset();
        do_key(14, e);
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      code = int'($urandom_range(0, 9));
            else if (r < 63) code = 10;
            else if (r < 70) code = 11;
            else if (r < 77) code = 12;
            else if (r < 91) code = 13;
            else if (r < 94) code = 14;
            else             code = int'($urandom_range(15, 31));
            model_key(code, me);
            do_key(code, e);
            chk($sformatf("rnd%0d_key%0d_err", n, code), e, me);
            build_exp(m_l1, m_mode == 2 ? $sformatf("%0d", m_res) : "");
            check_image($sformatf("rnd%0d_image", n));
            chk($sformatf("rnd%0d_valid", n), result_valid, m_mode == 2);
            chk($sformatf("rnd%0d_neg", n), result_neg, m_mode == 2 && m_res < 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
